// File: rtl/bomberman_pkg.sv
// Shared map geometry and slot state encoding for the bomb subsystem.
package bomberman_pkg;

    localparam int MAP_W    = 20;
    localparam int MAP_H    = 15;
    localparam int MAP_BITS = 300;

    typedef enum logic [1:0] {IDLE, FUSE, BLAST} slot_state_t;

    // Row-major tile index, identical to the map_1d layout; 299 fits in 9 bits.
    function automatic logic [8:0] tile_idx(input logic [4:0] x, input logic [3:0] y);
        return 9'(y) * 9'(MAP_W) + 9'(x);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FUSE/BLAST sequencing on frame ticks, with chain detonation input.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30,
    parameter int CNT_W        = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [4:0] x_i,
    input  logic [3:0] y_i,
    input  logic       chain_i,
    output logic       fuse_o,
    output logic       blast_o,
    output logic       active_o,
    output logic       free_o,
    output logic       fire_o,
    output logic [4:0] x_o,
    output logic [3:0] y_o
);

    slot_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       x_q;
    logic [3:0]       y_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (load_i) begin
            // A load always wins: the allocator only targets idle or just-freed slots.
            state_q <= FUSE;
            cnt_q   <= CNT_W'(FUSE_FRAMES);
            x_q     <= x_i;
            y_q     <= y_i;
        end else if (tick_i) begin
            case (state_q)
                FUSE: begin
                    if (cnt_q == CNT_W'(1) || chain_i) begin
                        state_q <= BLAST;
                        cnt_q   <= CNT_W'(BLAST_FRAMES);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                BLAST: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fuse_o   = (state_q == FUSE);
    assign blast_o  = (state_q == BLAST);
    assign active_o = (state_q != IDLE);
    assign fire_o   = tick_i && (state_q == FUSE) && (cnt_q == CNT_W'(1) || chain_i);
    assign free_o   = (state_q == IDLE) || (tick_i && state_q == BLAST && cnt_q == CNT_W'(1));
    assign x_o      = x_q;
    assign y_o      = y_q;

endmodule

// File: rtl/bomb_scheduler.sv
// Live-bomb resource owner: slot allocation, frame tick detect and registered bomb/blast overlays.
module bomb_scheduler
    import bomberman_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30,
    parameter int RANGE        = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         vs,
    input  logic         place_req,
    input  logic [4:0]   place_x,
    input  logic [3:0]   place_y,
    output logic         place_ack,
    output logic         place_nack,
    output logic [299:0] bomb_map,
    output logic [299:0] blast_map,
    output logic         explode_pulse,
    output logic [2:0]   active_count
);

    localparam int CNT_MAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic                 vs_q;
    logic                 tick;
    logic                 ack_q, nack_q, explode_q;
    logic [MAP_BITS-1:0]  bomb_map_q, blast_map_q, bomb_map_d, blast_map_d;
    logic [2:0]           active_count_q, active_count_d;

    logic [NUM_SLOTS-1:0] load, chain, fuse, blast, active, free, fire;
    logic [4:0]           sx [NUM_SLOTS];
    logic [3:0]           sy [NUM_SLOTS];
    logic                 in_range, dup, accept, found;

    assign tick = vs & ~vs_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        // Chain looks at the registered overlay, so a fresh blast ignites neighbours one tick later.
        assign chain[g] = blast_map_q[tile_idx(sx[g], sy[g])];

        bomb_slot #(
            .FUSE_FRAMES  (FUSE_FRAMES),
            .BLAST_FRAMES (BLAST_FRAMES),
            .CNT_W        (CNT_W)
        ) u_slot (
            .clk_i    (Clk),
            .rst_i    (Reset),
            .tick_i   (tick),
            .load_i   (load[g]),
            .x_i      (place_x),
            .y_i      (place_y),
            .chain_i  (chain[g]),
            .fuse_o   (fuse[g]),
            .blast_o  (blast[g]),
            .active_o (active[g]),
            .free_o   (free[g]),
            .fire_o   (fire[g]),
            .x_o      (sx[g]),
            .y_o      (sy[g])
        );
    end

    always_comb begin
        in_range = (place_x < 5'(MAP_W)) && (place_y < 4'(MAP_H));
        dup      = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (!free[s] && sx[s] == place_x && sy[s] == place_y) dup = 1'b1;
        end
        accept = place_req && in_range && !dup && (|free);
        found  = 1'b0;
        load   = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (accept && free[s] && !found) begin
                load[s] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        bomb_map_d     = '0;
        blast_map_d    = '0;
        active_count_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (active[s]) active_count_d = active_count_d + 3'd1;
            if (fuse[s]) bomb_map_d[tile_idx(sx[s], sy[s])] = 1'b1;
            if (blast[s]) begin
                blast_map_d[tile_idx(sx[s], sy[s])] = 1'b1;
                for (int d = 1; d <= RANGE; d++) begin
                    if (int'(sx[s]) >= d)        blast_map_d[tile_idx(sx[s] - 5'(d), sy[s])] = 1'b1;
                    if (int'(sx[s]) + d < MAP_W) blast_map_d[tile_idx(sx[s] + 5'(d), sy[s])] = 1'b1;
                    if (int'(sy[s]) >= d)        blast_map_d[tile_idx(sx[s], sy[s] - 4'(d))] = 1'b1;
                    if (int'(sy[s]) + d < MAP_H) blast_map_d[tile_idx(sx[s], sy[s] + 4'(d))] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q           <= 1'b0;
            ack_q          <= 1'b0;
            nack_q         <= 1'b0;
            explode_q      <= 1'b0;
            bomb_map_q     <= '0;
            blast_map_q    <= '0;
            active_count_q <= '0;
        end else begin
            vs_q           <= vs;
            ack_q          <= accept;
            nack_q         <= place_req && !accept;
            explode_q      <= |fire;
            bomb_map_q     <= bomb_map_d;
            blast_map_q    <= blast_map_d;
            active_count_q <= active_count_d;
        end
    end

    assign place_ack     = ack_q;
    assign place_nack    = nack_q;
    assign explode_pulse = explode_q;
    assign bomb_map      = bomb_map_q;
    assign blast_map     = blast_map_q;
    assign active_count  = active_count_q;

endmodule
